text_rom_arbiter: RTL and testbench
===================================

Name: text_rom_arbiter

Overview:
- Shares the single synchronous-read text ROM (14-bit address, 2-bit pixel data, 1-cycle read latency, 10001 entries) between two requesters.
- Port 0 is the VGA text-overlay pixel path and has priority. Port 1 is the banner/score string blitter, protected by a starvation limit.
- Drives the ROM address, tracks which port owns each in-flight read, and returns data to the owning port one cycle after grant.

Parameters:
- ADDR_W, 14, ROM address width.
- DATA_W, 2, ROM data width.
- ROM_DEPTH, 10001, number of valid ROM entries; addresses >= ROM_DEPTH are out of range.
- STARVE_LIMIT, 4, consecutive denied cycles of req1 after which port 1 is forced to win; range 1..15.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 read request, one read per cycle while high.
- addr0  in  ADDR_W  port 0 read address.
- gnt0  out  1  combinational; port 0 request accepted this cycle.
- rdata0  out  DATA_W  port 0 read data.
- valid0  out  1  rdata0 valid, 1-cycle pulse per granted read.
- req1  in  1  port 1 read request.
- addr1  in  ADDR_W  port 1 read address.
- gnt1  out  1  combinational; port 1 request accepted this cycle.
- rdata1  out  DATA_W  port 1 read data.
- valid1  out  1  rdata1 valid.
- rom_addr  out  ADDR_W  address to the ROM, sampled by the ROM at the Clk edge.
- rom_data  in  DATA_W  ROM output, registered inside the ROM.

Behaviour:
- Reset (sync): valid0/valid1 = 0, rdata0/rdata1 = 0, in-flight tag cleared, out-of-range flag cleared, starvation counter = 0, last address register = 0. While Reset is high: gnt0 = gnt1 = 0 and rom_addr = 0.
- Arbitration is combinational within the cycle (Reset low):
  - force1 = req1 && (starve_cnt >= STARVE_LIMIT).
  - gnt1 = req1 && (!req0 || force1).
  - gnt0 = req0 && !gnt1.
  - At most one grant per cycle. No grant when no request.
- rom_addr = addr of the granted port. With no grant, rom_addr holds the last granted address (register, reset 0).
- Starvation counter: 4-bit, saturating. Increment when req1 && !gnt1. Clear when gnt1 or !req1.
- Read pipeline: a grant in cycle t registers tag (port id), an issue bit, and an out-of-range bit (granted addr >= ROM_DEPTH). In cycle t+1, the owning port's valid = 1 and its rdata = rom_data, or 0 if out of range. The non-owning valid is 0 and its rdata holds its previous value.
- Throughput: one read per cycle total. Back-to-back grants to either port are allowed with no bubble.
- Latency: valid exactly 1 cycle after grant, fixed; no backpressure on return data.
- Requesters must hold req/addr until granted. The arbiter does not store denied requests.
- Out of range: the access is granted and consumes the cycle. Returned data is 0; rom_addr is still driven with the raw address, and the ROM result is ignored.
- Reset mid-operation: if Reset is high in cycle t+1 of an in-flight read, that read is dropped. No valid is produced and the counter is cleared.
- Simultaneous req0 and req1 with counter below limit: port 0 wins and the counter increments. At the limit: port 1 wins once, counter clears, then port 0 resumes priority.

Test Plan:
- ROM preloaded mem[5] = 2'h2. req0 = 1, addr0 = 5 for one cycle -> gnt0 = 1, rom_addr = 5 same cycle; next cycle valid0 = 1, rdata0 = 2; valid1 = 0.
- STARVE_LIMIT = 4, req0 and req1 held high for 10 cycles -> grant sequence 0,0,0,0,1,0,0,0,0,1; each port receives data 1 cycle after each of its grants.
- req1 alone, addr1 = 100, 101, 102 on consecutive cycles with mem = 1, 3, 0 -> valid1 high 3 consecutive cycles with rdata1 = 1, 3, 0.
- req0 with addr0 = 10001 -> gnt0 = 1; next cycle valid0 = 1, rdata0 = 0 regardless of rom_data.
- Grant port 1 in cycle t, assert Reset in t+1 -> valid1 = 0 in t+1 and t+2, gnt0 = gnt1 = 0 and rom_addr = 0 during Reset, counter = 0 afterwards.
- req1 held, req0 toggling 1,0,1,0 -> port 1 granted on every req0-low cycle and the counter never reaches the limit.

Source files
------------

// File: rtl/text_rom_arbiter.sv
// text_rom_arbiter
//   Shares one synchronous-read text ROM (1-cycle latency) between two
//   requesters. Port 0 (VGA text-overlay pixel path) has fixed priority;
//   port 1 (banner/score blitter) is guaranteed service once it has been
//   denied STARVE_LIMIT consecutive cycles. Each grant launches exactly one
//   ROM read; the data is steered back to the owning port one cycle later.
//
// Ports
//   Clk, Reset          rising-edge clock, synchronous active-high reset
//   req0/addr0          port 0 read request and address
//   gnt0                port 0 accepted this cycle (combinational)
//   rdata0/valid0       port 0 return data and 1-cycle valid pulse
//   req1/addr1          port 1 read request and address
//   gnt1                port 1 accepted this cycle (combinational)
//   rdata1/valid1       port 1 return data and 1-cycle valid pulse
//   rom_addr            address presented to the ROM (sampled at Clk edge)
//   rom_data            registered ROM output
module text_rom_arbiter #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned DATA_W       = 2,
  parameter int unsigned ROM_DEPTH    = 10001,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              valid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              valid1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // In-flight read bookkeeping (describes the read whose data is on rom_data)
  port_e             tag_q;
  logic              issue_q;
  logic              oor_q;

  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              force1;
  logic              gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_oor;
  logic [DATA_W-1:0] ret_data;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  assign force1 = req1 && (starve_cnt >= LIMIT);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!Reset) begin
      gnt1 = req1 && (!req0 || force1);
      gnt0 = req0 && !gnt1;
    end
  end

  assign gnt_any  = gnt0 || gnt1;
  assign gnt_addr = gnt1 ? addr1 : addr0;
  assign gnt_oor  = 32'(gnt_addr) >= ROM_DEPTH;

  // With no grant the ROM keeps seeing the last granted address so its
  // address bus does not toggle needlessly.
  always_comb begin
    rom_addr = last_addr_q;
    if (Reset) begin
      rom_addr = '0;
    end else if (gnt_any) begin
      rom_addr = gnt_addr;
    end
  end

  // ---------------------------------------------------------------------
  // Return path
  // ---------------------------------------------------------------------
  // Out-of-range reads still consume the ROM slot but return zero.
  assign ret_data = oor_q ? '0 : rom_data;

  // Reset in the return cycle drops the read.
  assign valid0 = !Reset && issue_q && (tag_q == PORT0);
  assign valid1 = !Reset && issue_q && (tag_q == PORT1);

  // The non-owning port keeps showing its previous data.
  assign rdata0 = valid0 ? ret_data : rdata0_q;
  assign rdata1 = valid1 ? ret_data : rdata1_q;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      issue_q     <= 1'b0;
      tag_q       <= PORT0;
      oor_q       <= 1'b0;
      starve_cnt  <= '0;
      last_addr_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      issue_q <= gnt_any;
      tag_q   <= gnt1 ? PORT1 : PORT0;
      oor_q   <= gnt_any && gnt_oor;

      if (gnt_any) begin
        last_addr_q <= gnt_addr;
      end

      // Counts consecutive denied cycles of port 1, saturating at 15.
      if (!req1 || gnt1) begin
        starve_cnt <= '0;
      end else if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (valid0) begin
        rdata0_q <= ret_data;
      end
      if (valid1) begin
        rdata1_q <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_text_rom_arbiter.sv
module tb_text_rom_arbiter;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 2;
  localparam int unsigned DEPTH = 10001;
  localparam int unsigned LIM   = 4;
  localparam int unsigned MEMSZ = 16384;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata0, rdata1;
  logic          valid0, valid1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  always #5 Clk = ~Clk;

  text_rom_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rdata0(rdata0), .valid0(valid0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rdata1(rdata1), .valid1(valid1),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  // Synchronous-read ROM, 1-cycle latency; filled over the whole address
  // space so out-of-range reads return non-zero garbage.
  logic [DW-1:0] mem [0:MEMSZ-1];
  always @(posedge Clk) rom_data <= mem[rom_addr];

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Reference model state
  int            denied  = 0;
  logic [AW-1:0] last_ga = '0;
  logic [DW-1:0] last0   = '0;
  logic [DW-1:0] last1   = '0;
  logic          mg0, mg1;
  logic          obs_g1;
  bit            mon_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_data(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) ? mem[a] : '0;
  endfunction

  // One clock cycle of stimulus plus the arbitration checks for that cycle.
  task automatic step(input logic r, input logic r0, input logic [AW-1:0] a0,
                      input logic r1, input logic [AW-1:0] a1);
    logic [AW-1:0] ea;
    exp_t          e;
    @(negedge Clk);
    Reset = r; req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
    if (r) begin
      mg0 = 1'b0; mg1 = 1'b0; ea = '0;
      q0.delete(); q1.delete();
      denied = 0; last_ga = '0; last0 = '0; last1 = '0;
    end else begin
      mg1 = r1 && (!r0 || denied >= int'(LIM));
      mg0 = r0 && !mg1;
      ea  = mg1 ? a1 : (mg0 ? a0 : last_ga);
      denied = (r1 && !mg1) ? denied + 1 : 0;
      if (mg1) begin e.d = ref_data(a1); e.due = cyc + 1; q1.push_back(e); end
      if (mg0) begin e.d = ref_data(a0); e.due = cyc + 1; q0.push_back(e); end
      if (mg0 || mg1) last_ga = ea;
    end
    check("gnt0", int'(gnt0), int'(mg0));
    check("gnt1", int'(gnt1), int'(mg1));
    check("rom_addr", int'(rom_addr), int'(ea));
    obs_g1 = gnt1;
  endtask

  // Monitor: pops the scoreboard whenever a response is due and compares.
  always @(negedge Clk) begin
    exp_t e;
    logic ev;
    #2;
    if (mon_en) begin
      ev = (q0.size() > 0) && (q0[0].due == cyc);
      check("valid0", int'(valid0), int'(ev));
      if (ev) begin
        e = q0.pop_front();
        check("rdata0", int'(rdata0), int'(e.d));
        last0 = e.d;
      end else if (!Reset) begin
        check("rdata0_hold", int'(rdata0), int'(last0));
      end
      ev = (q1.size() > 0) && (q1[0].due == cyc);
      check("valid1", int'(valid1), int'(ev));
      if (ev) begin
        e = q1.pop_front();
        check("rdata1", int'(rdata1), int'(e.d));
        last1 = e.d;
      end else if (!Reset) begin
        check("rdata1_hold", int'(rdata1), int'(last1));
      end
    end
  end

  initial begin
    logic [9:0]    seq;
    logic          p0, p1;
    logic [AW-1:0] pa0, pa1;
    logic          rr;

    Reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    for (int i = 0; i < int'(MEMSZ); i++) mem[i] = 2'($urandom);
    mem[5] = 2'h2;
    mem[100] = 2'h1; mem[101] = 2'h3; mem[102] = 2'h0;
    mem[DEPTH] = 2'h3;
    mem[MEMSZ-1] = 2'h1;

    // Reset: no grants, rom_addr 0; then return path idle and cleared
    for (int i = 0; i < 3; i++) step(1, 1, 14'd7, 1, 14'd9);
    step(0, 0, '0, 0, '0);
    check("reset_valid0", int'(valid0), 0);
    check("reset_valid1", int'(valid1), 0);
    check("reset_rdata0", int'(rdata0), 0);
    check("reset_rdata1", int'(rdata1), 0);
    mon_en = 1'b1;

    // Single port 0 read of mem[5]
    step(0, 1, 14'd5, 0, '0);
    step(0, 0, '0, 0, '0);

    // Both held: starvation limit forces port 1 every fifth cycle
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 14'($urandom_range(0, DEPTH - 1)), 1, 14'($urandom_range(0, DEPTH - 1)));
      seq = {seq[8:0], obs_g1};
    end
    check("starve_seq", int'(seq), int'(10'b0000100001));
    step(0, 0, '0, 0, '0);

    // Port 1 alone, back to back
    step(0, 0, '0, 1, 14'd100);
    step(0, 0, '0, 1, 14'd101);
    step(0, 0, '0, 1, 14'd102);
    step(0, 0, '0, 0, '0);

    // Out-of-range reads return zero
    step(0, 1, 14'(DEPTH), 0, '0);
    step(0, 0, '0, 1, 14'(MEMSZ - 1));
    step(0, 1, 14'(DEPTH - 1), 0, '0);
    step(0, 0, '0, 0, '0);

    // Grant port 1, then reset in the return cycle; afterwards counter is 0
    step(0, 1, 14'd3, 1, 14'd4);
    step(0, 1, 14'd3, 1, 14'd4);
    step(0, 0, '0, 1, 14'd200);
    step(1, 0, '0, 0, '0);
    step(0, 0, '0, 0, '0);
    seq = '0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 14'd11, 1, 14'd12);
      seq = {seq[8:0], obs_g1};
    end
    check("post_reset_seq", int'(seq), int'(10'b0000000001));
    step(0, 0, '0, 0, '0);

    // req1 held, req0 toggling: port 1 wins on every req0-low cycle
    for (int i = 0; i < 8; i++) begin
      step(0, (i % 2) == 0, 14'($urandom_range(0, DEPTH - 1)), 1, 14'($urandom_range(0, DEPTH - 1)));
      check("toggle_gnt1", int'(obs_g1), i % 2);
    end
    step(0, 0, '0, 0, '0);

    // Random traffic; requesters hold until granted
    p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!p0 && ($urandom_range(0, 99) < 60)) begin
        p0 = 1'b1;
        pa0 = ($urandom_range(0, 9) == 0) ? 14'($urandom_range(DEPTH, MEMSZ - 1))
                                          : 14'($urandom_range(0, DEPTH - 1));
      end
      if (!p1 && ($urandom_range(0, 99) < 50)) begin
        p1 = 1'b1;
        pa1 = ($urandom_range(0, 9) == 0) ? 14'($urandom_range(DEPTH, MEMSZ - 1))
                                          : 14'($urandom_range(0, DEPTH - 1));
      end
      rr = ($urandom_range(0, 199) == 0);
      step(rr, p0, pa0, p1, pa1);
      if (rr) begin
        p0 = 1'b0; p1 = 1'b0;
      end else begin
        if (mg0) p0 = 1'b0;
        if (mg1) p1 = 1'b0;
      end
    end

    step(0, 0, '0, 0, '0);
    step(0, 0, '0, 0, '0);
    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
